fdc_cpu_bridge: RTL and testbench



---
 rtl/fdc_bus_pkg.sv | 25 ++
 rtl/phi_timeout_ctr.sv | 31 +++
 rtl/fdc_cpu_bridge.sv | 138 +++++++++++++
 tb/tb_fdc_cpu_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_bus_pkg.sv
// Shared definitions for the CPU-to-wf1772 register bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fdc_bus_pkg;

    // Bridge sequencing: capture -> strobe -> wait for ack -> hold until the next phi_2
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fdc_state_e;

    // wf1772 register map (A1:A0)
    localparam logic [1:0] STATUS_CMD = 2'd0;
    localparam logic [1:0] TRACK      = 2'd1;
    localparam logic [1:0] SECTOR     = 2'd2;
    localparam logic [1:0] DATA       = 2'd3;

    localparam int         DEFAULT_ACK_TIMEOUT = 16;

    // Value an undriven CPU data bus reads back as; returned on an aborted read
    localparam logic [7:0] BUS_FLOAT = 8'hFF;

endpackage

// File: rtl/phi_timeout_ctr.sv
// Counts unacknowledged phi_2 pulses while the bridge waits on the controller.
// Latency: expire_o is combinational on the pulse that would reach LIMIT.
// Backpressure: none; clr_i has priority over en_i.
module phi_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;

    // Pulse counter, restarted for every new access
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 8'd0;
        end else if (clr_i) begin
            cnt_q <= 8'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // The enabled pulse that brings the count up to LIMIT is the abort pulse
    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/fdc_cpu_bridge.sv
// Turns phi_2-sampled CPU bus cycles into one-clk wf1772 register strobes and returns read data.
// Latency: strobe 1 clk after the capturing phi_2; cpu_dout/cpu_rdy update 1 clk after fdc_ack.
// Backpressure: a late ack pulls cpu_rdy low to stretch the CPU; ACK_TIMEOUT dead phi_2 pulses abort.
module fdc_cpu_bridge
    import fdc_bus_pkg::*;
#(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phi_2,
    input  logic              cpu_cs_n,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_dout_oe,
    output logic              cpu_rdy,
    output logic [ADDR_W-1:0] fdc_addr,
    output logic [DATA_W-1:0] fdc_wdata,
    output logic              fdc_rd_stb,
    output logic              fdc_wr_stb,
    input  logic [DATA_W-1:0] fdc_rdata,
    input  logic              fdc_ack,
    output logic              timeout_stb
);
    fdc_state_e        state_q;
    logic              rw_q;
    logic              rdy_q;
    logic              oe_q;
    logic              rd_stb_q;
    logic              wr_stb_q;
    logic              tmo_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dout_q;

    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_expire;

    assign tmo_clr = (state_q == ST_REQ);
    assign tmo_en  = (state_q == ST_WAIT) && phi_2 && !fdc_ack;

    phi_timeout_ctr #(
        .LIMIT (ACK_TIMEOUT)
    ) u_tmo_ctr (
        .clk_i    (clk),
        .rst_n_i  (reset),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    // Access sequencer with all CPU- and controller-facing outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rw_q     <= 1'b0;
            rdy_q    <= 1'b1;
            oe_q     <= 1'b0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            tmo_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dout_q   <= '0;
        end else begin
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            tmo_q    <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // A coincident-ack stretch only holds rdy low for the clk after the ack
                    if (!rdy_q) begin
                        rdy_q <= 1'b1;
                    end
                    // DONE ends on the same phi_2 that may start the next access
                    if (phi_2 && rdy_q) begin
                        if (!cpu_cs_n) begin
                            addr_q   <= cpu_addr;
                            rw_q     <= cpu_rw;
                            if (!cpu_rw) begin
                                wdata_q <= cpu_din;
                            end
                            rd_stb_q <= cpu_rw;
                            wr_stb_q <= !cpu_rw;
                            oe_q     <= cpu_rw;
                            state_q  <= ST_REQ;
                        end else begin
                            oe_q     <= 1'b0;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fdc_ack) begin
                        if (rw_q) begin
                            dout_q <= fdc_rdata;
                        end
                        // Ack on a phi_2 edge: the CPU already sampled, so stretch once more
                        rdy_q   <= !phi_2;
                        state_q <= ST_DONE;
                    end else if (phi_2) begin
                        if (tmo_expire) begin
                            if (rw_q) begin
                                dout_q <= '1;
                            end
                            tmo_q   <= 1'b1;
                            rdy_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            rdy_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_dout    = dout_q;
    assign cpu_dout_oe = oe_q;
    assign cpu_rdy     = rdy_q;
    assign fdc_addr    = addr_q;
    assign fdc_wdata   = wdata_q;
    assign fdc_rd_stb  = rd_stb_q;
    assign fdc_wr_stb  = wr_stb_q;
    assign timeout_stb = tmo_q;

endmodule

// File: tb/tb_fdc_cpu_bridge.sv
// Bench for fdc_cpu_bridge: plans every CPU access up front as a timeline of expected outputs
// per clk edge, plays the planned inputs, and compares all outputs on every edge.
module tb_fdc_cpu_bridge;

    localparam int NE   = 2000;   // clk edges simulated
    localparam int T    = 4;      // ACK_TIMEOUT of the DUT
    localparam int NSIG = 8;
    localparam int S_RDY = 0, S_OE = 1, S_DOUT = 2, S_ADDR = 3,
                   S_WDATA = 4, S_RD = 5, S_WR = 6, S_TMO = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       phi_2 = 1'b0;
    logic       cpu_cs_n = 1'b1;
    logic       cpu_rw = 1'b0;
    logic [1:0] cpu_addr = 2'd0;
    logic [7:0] cpu_din = 8'd0;
    logic [7:0] cpu_dout;
    logic       cpu_dout_oe;
    logic       cpu_rdy;
    logic [1:0] fdc_addr;
    logic [7:0] fdc_wdata;
    logic       fdc_rd_stb;
    logic       fdc_wr_stb;
    logic [7:0] fdc_rdata = 8'd0;
    logic       fdc_ack = 1'b0;
    logic       timeout_stb;

    fdc_cpu_bridge #(
        .ADDR_W      (2),
        .DATA_W      (8),
        .ACK_TIMEOUT (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .phi_2       (phi_2),
        .cpu_cs_n    (cpu_cs_n),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_dout_oe (cpu_dout_oe),
        .cpu_rdy     (cpu_rdy),
        .fdc_addr    (fdc_addr),
        .fdc_wdata   (fdc_wdata),
        .fdc_rd_stb  (fdc_rd_stb),
        .fdc_wr_stb  (fdc_wr_stb),
        .fdc_rdata   (fdc_rdata),
        .fdc_ack     (fdc_ack),
        .timeout_stb (timeout_stb)
    );

    always #5 clk = ~clk;

    // Edge index: after the n-th rising edge, cyc == n
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Planned inputs per edge (value sampled at that edge) and expected outputs after that edge
    bit         in_cs_n [NE];
    bit         in_rw   [NE];
    logic [1:0] in_addr [NE];
    logic [7:0] in_din  [NE];
    bit         in_ack  [NE];
    logic [7:0] in_rdata[NE];
    int         rst_evt [NE];   // 1: assert reset mid-cycle after this edge, 2: release
    int         ev [NSIG][NE];
    string      sig_name [NSIG] = '{"cpu_rdy", "cpu_dout_oe", "cpu_dout", "fdc_addr",
                                    "fdc_wdata", "fdc_rd_stb", "fdc_wr_stb", "timeout_stb"};

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input int edge_n, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0h want %0h", name, edge_n, act, exp);
    endtask

    task automatic set_from(input int s, input int n, input int v);
        for (int i = n; i < NE; i++) ev[s][i] = v;
    endtask

    // One CPU access captured at phi_2 edge p; k = ack delay in clk after the strobe (<=0: none).
    // Returns dn, the phi_2 edge on which the CPU cycle finally completes.
    task automatic plan(input int p, input bit rw, input logic [1:0] a, input logic [7:0] d,
                        input int k, input logic [7:0] rd, output int dn);
        int  ack_e;
        int  exp_e;
        bit  tmo;
        ack_e = (k > 0) ? p + 1 + k : -1;
        exp_e = p + 8 * T;
        tmo   = (k <= 0) || (ack_e > exp_e);
        ev[S_RD][p] = rw;
        ev[S_WR][p] = !rw;
        set_from(S_ADDR, p, a);
        if (!rw) set_from(S_WDATA, p, d);
        set_from(S_OE, p, rw);
        if (tmo) begin
            set_from(S_RDY, p + 8, 0);
            set_from(S_RDY, exp_e, 1);
            ev[S_TMO][exp_e] = 1;
            if (rw) set_from(S_DOUT, exp_e, 255);
            dn = exp_e + 8;
            if (ack_e > 0) begin
                in_ack[ack_e]   = 1'b1;   // arrives after the abort and must be ignored
                in_rdata[ack_e] = rd;
            end
        end else begin
            if (ack_e >= p + 8) set_from(S_RDY, p + 8, 0);
            set_from(S_RDY, (ack_e % 8 == 0) ? ack_e + 1 : ack_e, 1);
            if (rw) set_from(S_DOUT, ack_e, rd);
            in_ack[ack_e]   = 1'b1;
            in_rdata[ack_e] = rd;
            dn = (ack_e / 8 + 1) * 8;
            if (ack_e + 1 < dn && $urandom_range(0, 1) == 1)
                in_ack[$urandom_range(ack_e + 1, dn - 1)] = 1'b1;
        end
        set_from(S_OE, dn, 0);
        // CPU holds its bus (including chip select) until the cycle completes
        for (int i = p; i < dn; i++) begin
            in_cs_n[i] = 1'b0;
            in_rw[i]   = rw;
            in_addr[i] = a;
            in_din[i]  = d;
        end
    endtask

    task automatic drive(input int n);
        phi_2     = (n % 8 == 0);
        cpu_cs_n  = in_cs_n[n];
        cpu_rw    = in_rw[n];
        cpu_addr  = in_addr[n];
        cpu_din   = in_din[n];
        fdc_ack   = in_ack[n];
        fdc_rdata = in_rdata[n];
    endtask

    task automatic check_all(input int n, input int e_rdy, input int e_oe, input int e_dout,
                             input int e_addr, input int e_wdata, input int e_rd,
                             input int e_wr, input int e_tmo);
        chk(sig_name[S_RDY],   n, int'(cpu_rdy),     e_rdy);
        chk(sig_name[S_OE],    n, int'(cpu_dout_oe), e_oe);
        chk(sig_name[S_DOUT],  n, int'(cpu_dout),    e_dout);
        chk(sig_name[S_ADDR],  n, int'(fdc_addr),    e_addr);
        chk(sig_name[S_WDATA], n, int'(fdc_wdata),   e_wdata);
        chk(sig_name[S_RD],    n, int'(fdc_rd_stb),  e_rd);
        chk(sig_name[S_WR],    n, int'(fdc_wr_stb),  e_wr);
        chk(sig_name[S_TMO],   n, int'(timeout_stb), e_tmo);
    endtask

    // Compare process: every edge, all outputs against the planned timeline
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc < NE)
                check_all(cyc, ev[S_RDY][cyc], ev[S_OE][cyc], ev[S_DOUT][cyc], ev[S_ADDR][cyc],
                          ev[S_WDATA][cyc], ev[S_RD][cyc], ev[S_WR][cyc], ev[S_TMO][cyc]);
        end
    end

    initial begin
        int p;
        int d;
        int r;
        int k;
        int cnt;
        // Background: idle bus noise; chip select only meaningful on phi_2 edges
        for (int n = 0; n < NE; n++) begin
            in_cs_n[n]  = (n % 8 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_rw[n]    = 1'($urandom_range(0, 1));
            in_addr[n]  = 2'($urandom_range(0, 3));
            in_din[n]   = 8'($urandom_range(0, 255));
            in_ack[n]   = 1'b0;
            in_rdata[n] = 8'($urandom_range(0, 255));
            rst_evt[n]  = 0;
            for (int s = 0; s < NSIG; s++) ev[s][n] = (s == S_RDY) ? 1 : 0;
        end
        rst_evt[2] = 2;

        // Write, fast ack
        p = 16;
        plan(p, 1'b0, 2'd1, 8'h5A, 2, 8'h00, d);
        chk("t1_wr_stb",  -1, ev[S_WR][p], 1);
        chk("t1_addr",    -1, ev[S_ADDR][p], 1);
        chk("t1_wdata",   -1, ev[S_WDATA][p], 'h5A);
        chk("t1_rdy",     -1, ev[S_RDY][p + 3], 1);
        chk("t1_oe",      -1, ev[S_OE][p + 3], 0);
        chk("t1_done",    -1, d, p + 8);
        // Read, fast ack, back-to-back with the write
        p = d;
        plan(p, 1'b1, 2'd3, 8'h00, 3, 8'hC3, d);
        chk("t2_dout",    -1, ev[S_DOUT][p + 4], 'hC3);
        chk("t2_oe_held", -1, ev[S_OE][p + 7], 1);
        chk("t2_oe_drop", -1, ev[S_OE][d], 0);
        // Slow read ack: 12 clk after the strobe
        p = d + 8;
        plan(p, 1'b1, 2'd0, 8'h00, 12, 8'h3C, d);
        chk("t3_rdy_pre",  -1, ev[S_RDY][p + 7], 1);
        chk("t3_rdy_low",  -1, ev[S_RDY][p + 8], 0);
        chk("t3_rdy_hold", -1, ev[S_RDY][p + 12], 0);
        chk("t3_rdy_back", -1, ev[S_RDY][p + 13], 1);
        cnt = 0;
        for (int i = p; i < d; i++) cnt += ev[S_RD][i];
        chk("t3_one_stb",  -1, cnt, 1);
        // Ack coincident with phi_2 (7 clk after the strobe)
        p = d;
        plan(p, 1'b1, 2'd2, 8'h00, 7, 8'h96, d);
        chk("t4_rdy_low",  -1, ev[S_RDY][p + 8], 0);
        chk("t4_rdy_back", -1, ev[S_RDY][p + 9], 1);
        chk("t4_dout",     -1, ev[S_DOUT][p + 8], 'h96);
        chk("t4_done",     -1, d, p + 16);
        // Timeout with a stray ack after the abort
        p = d;
        plan(p, 1'b1, 2'd1, 8'h00, 8 * T + 2, 8'h11, d);
        chk("t5_tmo",      -1, ev[S_TMO][p + 32], 1);
        chk("t5_dout",     -1, ev[S_DOUT][p + 32], 'hFF);
        chk("t5_rdy_low",  -1, ev[S_RDY][p + 31], 0);
        chk("t5_rdy_back", -1, ev[S_RDY][p + 32], 1);
        chk("t5_stray",    -1, ev[S_DOUT][p + 36], 'hFF);
        chk("t5_done",     -1, d, p + 40);
        // Reset during WAIT of a read
        p = d + 8;
        ev[S_RD][p] = 1;
        set_from(S_OE, p, 1);
        set_from(S_ADDR, p, 2);
        for (int i = p; i < p + 4; i++) begin
            in_cs_n[i] = 1'b0; in_rw[i] = 1'b1; in_addr[i] = 2'd2;
        end
        for (int s = 0; s < NSIG; s++) set_from(s, p + 4, (s == S_RDY) ? 1 : 0);
        rst_evt[p + 3] = 1;
        rst_evt[p + 5] = 2;
        // Back-to-back reads after reset
        p = p + 16;
        plan(p, 1'b1, 2'd3, 8'h00, 2, 8'hA5, d);
        chk("t6_b2b",      -1, d, p + 8);
        plan(d, 1'b1, 2'd1, 8'h00, 4, 8'h5A, d);
        chk("t6_stb_a",    -1, ev[S_RD][p], 1);
        chk("t6_stb_b",    -1, ev[S_RD][p + 8], 1);
        // Randomized accesses
        p = d + 8 * $urandom_range(0, 1);
        while (p < NE - 60) begin
            r = $urandom_range(0, 7);
            k = (r == 0) ? -1 : (r < 4) ? $urandom_range(1, 7) : $urandom_range(8, 38);
            plan(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), k, 8'($urandom_range(0, 255)), d);
            p = d + 8 * $urandom_range(0, 2);
        end

        // Play the plan
        drive(1);
        for (int n = 1; n < NE; n++) begin
            @(posedge clk);
            #2;
            if (n + 1 < NE) drive(n + 1);
            if (rst_evt[n] == 1) begin
                #3;
                reset = 1'b0;
                #1;
                check_all(n, 1, 0, 0, 0, 0, 0, 0, 0);
            end else if (rst_evt[n] == 2) begin
                #3;
                reset = 1'b1;
            end
        end
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
